core_ctrl: RTL

Instruction sequencer that drives the 50-bit `inst` bus and observes `ofifo_valid` of the core datapath. It is the initiator side of that interface.
For one tile it issues the whole command stream:
- weight fetch from xmem into L0, then kernel load into the PE array;
- activation fetch into L0, then execute;
- OFIFO drain into pmem.
It replaces hand-written testbench instruction vectors and sits directly above `core`.

---
 rtl/core_ctrl_pkg.sv | 44 ++++
 rtl/core_ctrl_fetch.sv | 66 ++++++
 rtl/core_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared definitions for the core_ctrl instruction sequencer.
//   - state_e    : sequencer states, exposed on the core_ctrl state port
//   - B_*        : bit positions inside the 50-bit inst word
//   - INST_IDLE  : the do-nothing instruction word (all strobes inactive)
// Optional feature macro used by the design: CORE_CTRL_ACC_EN.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_FETCH,
        W_LOAD,
        W_WAIT,
        X_FETCH,
        X_EXEC,
        DRAIN,
        ACC,
        DONE
    } state_e;

    localparam int INST_W = 50;

    // inst field map (CEN/WEN are active-low)
    localparam int B_ACC      = 49;
    localparam int B_CEN_P    = 48;
    localparam int B_WEN_P    = 47;
    localparam int B_AP_LSB   = 33;  // A_pmem [46:33]
    localparam int B_CEN1     = 32;
    localparam int B_A1_LSB   = 21;  // A1_xmem [31:21]
    localparam int B_CEN0     = 20;
    localparam int B_WEN0     = 19;
    localparam int B_A0_LSB   = 8;   // A0_xmem [18:8]
    localparam int B_OFIFO_RD = 7;
    localparam int B_IFIFO_WR = 6;
    localparam int B_IFIFO_RD = 5;
    localparam int B_L0_RD    = 4;
    localparam int B_L0_WR    = 3;
    localparam int B_MODE     = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Bits 48, 47, 32, 20, 19 set: both memories disabled, no writes, no strobes.
    localparam logic [INST_W-1:0] INST_IDLE = 50'h1_8001_0018_0000;

endpackage

// File: rtl/core_ctrl_fetch.sv
// core_ctrl_fetch: xmem-to-L0 fetch engine shared by the weight and
// activation fetch phases.
// A go pulse latches base/count and runs count+1 cycles:
//   cycles 0..count-1 : xmem read (cen=0) of address base+i
//   cycles 1..count   : l0_wr=1 (xmem data arrives one cycle after the read)
// last is high in the final cycle (cycle count).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   go                 : start a fetch run (ignored effects mid-run: restarts)
//   base [AW_X]        : first xmem address
//   count [LW]         : number of words, must be >= 1
//   cen                : active-low xmem chip enable for port 0
//   addr [AW_X]        : xmem port-0 address (0 when not reading)
//   l0_wr              : L0 write strobe
//   last               : final cycle of the run
module core_ctrl_fetch #(
    parameter int AW_X = 11,
    parameter int LW   = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [AW_X-1:0] base,
    input  logic [LW-1:0]   count,
    output logic            cen,
    output logic [AW_X-1:0] addr,
    output logic            l0_wr,
    output logic            last
);

    logic            active;
    logic [LW-1:0]   idx;
    logic [LW-1:0]   count_r;
    logic [AW_X-1:0] base_r;
    logic            reading;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            idx     <= '0;
            count_r <= '0;
            base_r  <= '0;
        end else if (go) begin
            active  <= 1'b1;
            idx     <= '0;
            count_r <= count;
            base_r  <= base;
        end else if (active) begin
            if (idx == count_r) begin
                active <= 1'b0;
                idx    <= '0;
            end else begin
                idx <= idx + LW'(1);
            end
        end
    end

    // idx never exceeds count_r, so "not equal" means "still reading".
    assign reading = active && (idx != count_r);
    assign cen     = ~reading;
    // Address wraps modulo 2^AW_X by truncation.
    assign addr    = reading ? (base_r + AW_X'(idx)) : '0;
    assign l0_wr   = active && (idx != '0);
    assign last    = active && (idx == count_r);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer driving the 50-bit inst bus of core.
// For one tile it issues: weight fetch xmem->L0, kernel load, wait,
// activation fetch xmem->L0, execute, OFIFO drain into pmem, and
// (with CORE_CTRL_ACC_EN defined and acc_en=1) an accumulate pass.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   acc_en         : (CORE_CTRL_ACC_EN only) run the accumulate pass
//   start          : one-cycle pulse, accepted only in IDLE
//   w_base, x_base : xmem addresses of first weight / activation word
//   p_base         : pmem address of first output vector
//   len            : activation vectors per tile (0 is treated as 1)
//   ofifo_valid    : OFIFO holds at least one vector
//   inst           : registered instruction word to core
//   busy           : high from the cycle after an accepted start until done
//   done           : one-cycle completion pulse
//   state          : current sequencer state (observation only)
// Timing: inst/busy/done are registered from the current state, so the word
// generated in a state appears on inst during the following cycle.
// Optional feature macro: CORE_CTRL_ACC_EN.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int LOAD_WAIT = row + col,
    parameter int AW_X      = 11,
    parameter int AW_P      = 14,
    parameter int LW        = 11
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CORE_CTRL_ACC_EN
    input  logic              acc_en,
`endif
    input  logic              start,
    input  logic [AW_X-1:0]   w_base,
    input  logic [AW_X-1:0]   x_base,
    input  logic [AW_P-1:0]   p_base,
    input  logic [LW-1:0]     len,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output state_e            state
);

    // Counter wide enough for row, LOAD_WAIT and len+1.
    localparam int CW = 16;
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] ROW_LAST  = CW'(row - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(LOAD_WAIT - 1);

    state_e            state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [INST_W-1:0] inst_n;
    logic              busy_n, done_n;
    logic              latch_cfg;

    // Configuration captured when start is accepted
    logic [AW_X-1:0]   x_base_r;
    logic [AW_P-1:0]   p_base_r;
    logic [LW-1:0]     len_r;
    logic [LW-1:0]     len_eff;
    logic [CW-1:0]     len_c;
`ifdef CORE_CTRL_ACC_EN
    logic              acc_en_r;
`endif

    // Fetch engine interface
    logic              f_go;
    logic [AW_X-1:0]   f_base;
    logic [LW-1:0]     f_count;
    logic              f_cen;
    logic [AW_X-1:0]   f_addr;
    logic              f_l0_wr;
    logic              f_last;

    assign len_eff = (len == '0) ? LW'(1) : len;
    assign len_c   = CW'(len_r);

    core_ctrl_fetch #(
        .AW_X (AW_X),
        .LW   (LW)
    ) u_fetch (
        .clk   (clk),
        .reset (reset),
        .go    (f_go),
        .base  (f_base),
        .count (f_count),
        .cen   (f_cen),
        .addr  (f_addr),
        .l0_wr (f_l0_wr),
        .last  (f_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            inst     <= INST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            x_base_r <= '0;
            p_base_r <= '0;
            len_r    <= '0;
`ifdef CORE_CTRL_ACC_EN
            acc_en_r <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            inst  <= inst_n;
            busy  <= busy_n;
            done  <= done_n;
            if (latch_cfg) begin
                x_base_r <= x_base;
                p_base_r <= p_base;
                len_r    <= len_eff;
`ifdef CORE_CTRL_ACC_EN
                acc_en_r <= acc_en;
`endif
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        inst_n    = INST_IDLE;
        busy_n    = busy;
        done_n    = 1'b0;
        latch_cfg = 1'b0;
        f_go      = 1'b0;
        f_base    = x_base_r;
        f_count   = len_r;

        case (state)
            IDLE: begin
                if (start) begin
                    // Config is not latched yet, so the weight fetch takes
                    // w_base straight from the port.
                    latch_cfg = 1'b1;
                    f_go      = 1'b1;
                    f_base    = w_base;
                    f_count   = LW'(row);
                    busy_n    = 1'b1;
                    cnt_n     = '0;
                    state_n   = W_FETCH;
                end
            end

            W_FETCH, X_FETCH: begin
                inst_n[B_CEN0]              = f_cen;
                inst_n[B_A0_LSB +: AW_X]    = f_addr;
                inst_n[B_L0_WR]             = f_l0_wr;
                if (f_last) begin
                    cnt_n   = '0;
                    state_n = (state == W_FETCH) ? W_LOAD : X_EXEC;
                end
            end

            W_LOAD: begin
                inst_n[B_L0_RD] = 1'b1;
                inst_n[B_LOAD]  = 1'b1;
                if (cnt == ROW_LAST) begin
                    cnt_n   = '0;
                    state_n = W_WAIT;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end

            W_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    f_go    = 1'b1;
                    cnt_n   = '0;
                    state_n = X_FETCH;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end

            X_EXEC: begin
                inst_n[B_L0_RD] = 1'b1;
                inst_n[B_EXEC]  = 1'b1;
                if (cnt == len_c - ONE) begin
                    cnt_n   = '0;
                    state_n = DRAIN;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end

            DRAIN: begin
                // OFIFO is first-word-fall-through: pop and pmem write
                // go out in the same word.
                if (ofifo_valid) begin
                    inst_n[B_OFIFO_RD]        = 1'b1;
                    inst_n[B_CEN_P]           = 1'b0;
                    inst_n[B_WEN_P]           = 1'b0;
                    inst_n[B_AP_LSB +: AW_P]  = p_base_r + AW_P'(cnt);
                    if (cnt == len_c - ONE) begin
                        cnt_n = '0;
`ifdef CORE_CTRL_ACC_EN
                        state_n = acc_en_r ? ACC : DONE;
`else
                        state_n = DONE;
`endif
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end

`ifdef CORE_CTRL_ACC_EN
            ACC: begin
                // pmem read latency is one cycle, so acc trails the read.
                if (cnt != len_c) begin
                    inst_n[B_CEN_P]          = 1'b0;
                    inst_n[B_AP_LSB +: AW_P] = p_base_r + AW_P'(cnt);
                end
                if (cnt != '0) begin
                    inst_n[B_ACC] = 1'b1;
                end
                if (cnt == len_c) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
`endif

            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
